// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//
// Elastic register between two CPU pipeline stages. It carries a data payload
// plus a control field, and adds three things:
//   - valid/ready flow control, so a downstream stall holds the stage;
//   - a synchronous flush that squashes every held entry;
//   - bubble gating, which forces out_ctrl_o to zero whenever the stage is empty.
//
// Build option:
//   PIPE_STAGE_SKID_EN  When defined, the stage has a main entry plus a skid
//                       entry, and in_ready_o is driven from flops only.
//                       When undefined, the stage has a single entry, and
//                       in_ready_o is combinational from out_ready_i.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   upstream offers a payload
//   in_ready_o   stage accepts a payload this cycle
//   in_data_i    upstream payload (DATA_W bits)
//   in_ctrl_i    upstream control bits (CTRL_W bits)
//   flush_i      synchronous squash of all entries; highest priority
//   out_valid_o  stage presents a payload
//   out_ready_i  downstream consumes the head this cycle
//   out_data_o   head payload
//   out_ctrl_o   head control bits; zero when out_valid_o is low
//   count_o      number of entries held (0..2)
module pipe_stage_elastic #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        count_o
);

    // Main (head) entry, shared by both builds.
    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic              main_load;

    logic accept;
    logic pop;

    // A flush cycle never counts as a transfer out; downstream sees the same flush.
    assign pop = main_valid_q & out_ready_i & ~flush_i;

`ifdef PIPE_STAGE_SKID_EN

    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              skid_load;
    logic              main_sel_skid;

    // Ready is "skid empty", a pure flop output; the skid catches the one
    // payload that may arrive while main is stalled.
    assign in_ready_o = ~skid_valid_q;
    assign accept     = in_valid_i & ~skid_valid_q & ~flush_i;

    always_comb begin
        main_valid_d  = main_valid_q;
        skid_valid_d  = skid_valid_q;
        main_load     = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || pop) begin
            // Main is free at this edge: refill from skid first to keep order.
            if (skid_valid_q) begin
                main_load     = 1'b1;
                main_sel_skid = 1'b1;
                main_valid_d  = 1'b1;
                skid_valid_d  = 1'b0;
            end else if (accept) begin
                main_load    = 1'b1;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    assign main_data_d = main_sel_skid ? skid_data_q : in_data_i;
    assign main_ctrl_d = main_sel_skid ? skid_ctrl_q : in_ctrl_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            if (skid_load) begin
                skid_data_q <= in_data_i;
                skid_ctrl_q <= in_ctrl_i;
            end
        end
    end

    assign count_o = {main_valid_q & skid_valid_q, main_valid_q ^ skid_valid_q};

`else

    // Single entry: a draining head frees the slot in the same cycle.
    assign in_ready_o = ~main_valid_q | out_ready_i;
    assign accept     = in_valid_i & in_ready_o & ~flush_i;

    always_comb begin
        main_valid_d = main_valid_q;
        main_load    = 1'b0;
        if (flush_i) begin
            main_valid_d = 1'b0;
        end else if (accept) begin
            main_load    = 1'b1;
            main_valid_d = 1'b1;
        end else if (pop) begin
            main_valid_d = 1'b0;
        end
    end

    assign main_data_d = in_data_i;
    assign main_ctrl_d = in_ctrl_i;

    assign count_o = {1'b0, main_valid_q};

`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            if (main_load) begin
                main_data_q <= main_data_d;
                main_ctrl_q <= main_ctrl_d;
            end
        end
    end

    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;
    // Bubble gating: an empty or squashed stage never asserts control downstream.
    assign out_ctrl_o  = main_valid_q ? main_ctrl_q : '0;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    count;

    pipe_stage_elastic #(
        .DATA_W (DW),
        .CTRL_W (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_ctrl_i   (in_ctrl),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_ctrl_o  (out_ctrl),
        .count_o     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic [CW-1:0] ic;
        logic          fl;
        logic          ordy;
        logic          e_irdy;  // in_ready before the edge
        logic          e_ov;    // after the edge
        logic [DW-1:0] e_od;
        logic [CW-1:0] e_oc;
        logic [1:0]    e_cnt;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    vec_t vecs[9];
    ent_t q[$];

    initial begin
        // Stream 0x1..0x8 with out_ready held high, then one idle cycle.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, DW'(i + 1), CW'(i + 1), 1'b0, 1'b1,
                        1'b1, 1'b1, DW'(i + 1), CW'(i + 1), 2'd1};
        end
        vecs[8] = '{1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 2'd0};

        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data", 64'(out_data), 64'd0);
        chk("reset out_ctrl", 64'(out_ctrl), 64'd0);
        chk("reset count", 64'(count), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        do_reset();

        // ---------------- table-driven stream ----------------
        for (int i = 0; i < 9; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            in_ctrl   = vecs[i].ic;
            flush     = vecs[i].fl;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("stream[%0d] in_ready", i), 64'(in_ready), 64'(vecs[i].e_irdy));
            step();
            chk($sformatf("stream[%0d] out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            if (vecs[i].e_ov)
                chk($sformatf("stream[%0d] out_data", i), 64'(out_data), 64'(vecs[i].e_od));
            chk($sformatf("stream[%0d] out_ctrl", i), 64'(out_ctrl), 64'(vecs[i].e_oc));
            chk($sformatf("stream[%0d] count", i), 64'(count), 64'(vecs[i].e_cnt));
        end

        // ---------------- stall ----------------
        do_reset();
        in_valid = 1'b1; in_data = 32'hA5; in_ctrl = 6'h21; out_ready = 1'b0;
        step();
        in_data = 32'hB6; in_ctrl = 6'h12;
        for (int i = 0; i < 5; i++) begin
            #1;
`ifdef PIPE_STAGE_SKID_EN
            chk("stall in_ready", 64'(in_ready), (i == 0) ? 64'd1 : 64'd0);
`else
            chk("stall in_ready", 64'(in_ready), 64'd0);
`endif
            step();
            chk("stall out_data", 64'(out_data), 64'hA5);
            chk("stall out_ctrl", 64'(out_ctrl), 64'h21);
`ifdef PIPE_STAGE_SKID_EN
            chk("stall count", 64'(count), 64'd2);
`else
            chk("stall count", 64'(count), 64'd1);
`endif
        end
        // Release: single-entry takes 0xB6 now as a replace; skid already holds it.
        out_ready = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
        in_valid = 1'b0;
`endif
        #1;
        chk("release head", 64'(out_data), 64'hA5);
        step();
        in_valid = 1'b0;
        chk("release second valid", 64'(out_valid), 64'd1);
        chk("release second data", 64'(out_data), 64'hB6);
        chk("release second ctrl", 64'(out_ctrl), 64'h12);
        step();
        chk("release drained", 64'(out_valid), 64'd0);
        chk("release count", 64'(count), 64'd0);

        // ---------------- flush + bubble ----------------
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; in_ctrl = 6'h05;
        step();
`ifdef PIPE_STAGE_SKID_EN
        in_data = 32'h22; in_ctrl = 6'h0A;
        step();
        chk("preflush count", 64'(count), 64'd2);
`else
        chk("preflush count", 64'(count), 64'd1);
`endif
        flush = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hEE; in_ctrl = 6'h3F;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush out_valid", 64'(out_valid), 64'd0);
        chk("flush out_ctrl", 64'(out_ctrl), 64'd0);
        chk("flush count", 64'(count), 64'd0);
        chk("flush in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bubble out_valid", 64'(out_valid), 64'd0);
            chk("bubble out_ctrl", 64'(out_ctrl), 64'd0);
        end

        // ---------------- async reset mid-cycle ----------------
        in_valid = 1'b1; in_data = 32'h77; in_ctrl = 6'h33; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("prereset out_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", 64'(out_valid), 64'd0);
        chk("async out_ctrl", 64'(out_ctrl), 64'd0);
        chk("async out_data", 64'(out_data), 64'd0);
        chk("async count", 64'(count), 64'd0);
        chk("async in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // ---------------- randomized vs queue model ----------------
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic exp_rdy;
            in_valid  = ($urandom_range(99) < 60);
            in_data   = $urandom;
            in_ctrl   = CW'($urandom);
            out_ready = ($urandom_range(99) < 60);
            flush     = ($urandom_range(99) < 4);
            #1;
`ifdef PIPE_STAGE_SKID_EN
            exp_rdy = (q.size() < 2);
`else
            exp_rdy = (q.size() == 0) || out_ready;
`endif
            chk("rand in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("rand out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("rand count", 64'(count), 64'(q.size()));
            if (q.size() != 0) begin
                chk("rand out_data", 64'(out_data), 64'(q[0].d));
                chk("rand out_ctrl", 64'(out_ctrl), 64'(q[0].c));
            end else begin
                chk("rand out_ctrl", 64'(out_ctrl), 64'd0);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (in_valid && exp_rdy) q.push_back('{d: in_data, c: in_ctrl});
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
